divide_control: RTL and testbench
=================================

Name: divide_control

Overview:
- Sequential shift-subtract (restoring) unsigned divider: controller plus its own small datapath.
- Inverse of the shift-add multiplier control in the same arithmetic unit.
- Execute is a hold-style switch. One press runs exactly one division, then the block parks in Halt until Execute is released.
- Sits beside the multiplier. Operands come from switch registers; results drive the display/register file.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- Execute  input  1  start switch, level-sensitive, held by the user.
- Dividend  input  WIDTH  unsigned dividend, sampled only in Load.
- Divisor  input  WIDTH  unsigned divisor, sampled only in Load.
- Quotient  output  WIDTH  result quotient.
- Remainder  output  WIDTH  result remainder.
- Busy  output  1  high in Load, Shift, Sub.
- Done  output  1  high in Halt.
- Div_By_Zero  output  1  sticky flag for the last operation; set when Divisor was 0 at Load.

Behaviour:
- Reset (Reset=0, async): state=Start; count, quotient register Q, remainder register R, divisor register D all 0. Quotient=0, Remainder=0, Busy=0, Done=0, Div_By_Zero=0. Reset mid-operation aborts immediately; no partial result is kept.
- States: Start, Load, Shift, Sub, Halt. Two-process FSM: registered state, combinational next-state.
- Start: if Execute=1 -> Load, else stay. Outputs keep the previous results.
- Load (1 cycle):
  - Q<=Dividend; D<=Divisor; R<=0; count<=WIDTH; Div_By_Zero<=(Divisor==0).
  - If Divisor==0 -> Halt, with Q<=all ones and R<=Dividend.
  - Otherwise -> Shift.
- Shift (1 cycle): {R,Q} <= {R,Q} << 1; Q[0]<=0 -> Sub.
- Sub (1 cycle):
  - Compute trial = {1'b0,R} - {1'b0,D} at WIDTH+1 bits.
  - If trial MSB==0 (no borrow): R<=trial[WIDTH-1:0] and Q[0]<=1. Otherwise R and Q[0] are unchanged.
  - count<=count-1. If count==1 -> Halt, else -> Shift.
- Halt: Done=1. If Execute=0 -> Start, else stay. A held switch must never start a second division.
- Quotient=Q and Remainder=R at all times. Values are only guaranteed in Halt and after, and hold until the next Load.
- Latency: Execute sampled high in Start at edge k -> Load at k+1 -> Halt entered at edge k+1+2*WIDTH. For WIDTH=8, Done rises 17 cycles after Load is entered. Divide-by-zero: Halt one cycle after Load.
- R never exceeds D-1 after any Sub. The width-(WIDTH+1) trial prevents wrap-around when R has its MSB set after the shift.
- Dividend/Divisor changes after Load have no effect on the running operation.
- Busy and Done are decoded from state only; they are never high together.
- Illegal state encodings return to Start on the next clock.

Test Plan:
- Reset=0 then 1, Execute=0 -> Start; Quotient=0, Remainder=0, Busy=0, Done=0, Div_By_Zero=0.
- Dividend=100, Divisor=7, press Execute -> Busy for 17 cycles, then Done=1, Quotient=14, Remainder=2, Div_By_Zero=0.
- Boundaries, each with a fresh press:
  - 255/1 -> Q=255, R=0
  - 255/255 -> Q=1, R=0
  - 5/9 -> Q=0, R=5
  - 128/3 -> Q=42, R=2
  - 0/13 -> Q=0, R=0
- Divisor=0, Dividend=200 -> Halt 1 cycle after Load; Quotient=8'hFF, Remainder=200, Div_By_Zero=1. A following 9/4 press -> Q=2, R=1, Div_By_Zero=0.
- Execute held high for 50 cycles -> exactly one division, stays in Halt. Release -> Start, results unchanged. Change Dividend mid-operation -> result reflects the value sampled at Load.
- Start 100/7, drive Reset=0 asynchronously (between clock edges) on the 5th cycle of Busy -> all outputs 0 immediately. Release Reset with Execute=1 -> a new division starts and completes correctly (Q=14, R=2).

Source files
------------

// File: rtl/divide_control.sv
// ---------------------------------------------------------------------------
// divide_control
//
// Sequential shift-subtract (restoring) unsigned divider with its own small
// datapath. One press of the Execute switch runs exactly one division.
// The block then parks in Halt until the switch is released, so a held
// switch can never start a second division.
//
// Handshake: Execute is a level, not a pulse. A division starts when
// Execute=1 is seen in Start. Busy is high while the operation runs
// (Load/Shift/Sub). Done is high in Halt, and stays high until Execute is
// seen low. Operands are captured only in Load.
//
// Ports:
//   Clk          system clock, all state updates on posedge
//   Reset        asynchronous active-low reset
//   Execute      start switch, level-sensitive
//   Dividend     unsigned dividend, sampled in Load
//   Divisor      unsigned divisor, sampled in Load
//   Quotient     quotient register Q
//   Remainder    remainder register R
//   Busy         high in Load, Shift, Sub
//   Done         high in Halt
//   Div_By_Zero  set when the divisor captured in Load was zero
// ---------------------------------------------------------------------------
module divide_control #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  localparam int CW = $clog2(WIDTH + 1);

  // state_q is the observable FSM state for checkers and debug.
  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SUB   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, done_q;

  // One extra bit, so that a remainder with its MSB set after the shift
  // cannot wrap around and look like a successful subtraction.
  logic [WIDTH:0]   trial;

  assign trial = {1'b0, rem_q} - {1'b0, dvs_q};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: if (Execute) state_d = ST_LOAD;
      ST_LOAD:  state_d = (Divisor == '0) ? ST_HALT : ST_SHIFT;
      ST_SHIFT: state_d = ST_SUB;
      ST_SUB:   state_d = (count_q == CW'(1)) ? ST_HALT : ST_SHIFT;
      ST_HALT:  if (!Execute) state_d = ST_START;
      // Illegal encodings recover to Start.
      default:  state_d = ST_START;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_LOAD: begin
        dvs_d   = Divisor;
        count_d = CW'(WIDTH);
        dbz_d   = (Divisor == '0);
        if (Divisor == '0) begin
          // Divide by zero: all-ones quotient, dividend kept as remainder.
          quo_d = '1;
          rem_d = Dividend;
        end else begin
          quo_d = Dividend;
          rem_d = '0;
        end
      end
      ST_SHIFT: begin
        // {R,Q} shifts left as one register; a zero enters Q[0].
        {rem_d, quo_d} = {rem_q, quo_q} << 1;
      end
      ST_SUB: begin
        if (!trial[WIDTH]) begin
          rem_d    = trial[WIDTH-1:0];
          quo_d[0] = 1'b1;
        end
        count_d = count_q - CW'(1);
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_START;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
      dbz_q   <= dbz_d;
      // Registered from the next state, so they track state_q exactly.
      busy_q  <= (state_d == ST_LOAD) || (state_d == ST_SHIFT) ||
                 (state_d == ST_SUB);
      done_q  <= (state_d == ST_HALT);
    end
  end

  assign Quotient    = quo_q;
  assign Remainder   = rem_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_busy_done_excl : assert property (@(posedge Clk) disable iff (!Reset)
    !(busy_q && done_q));

  a_rem_below_divisor : assert property (@(posedge Clk) disable iff (!Reset)
    (state_q == ST_SUB) |=> (rem_q < dvs_q));

endmodule

// File: tb/tb_divide_control.sv
module tb_divide_control;

  localparam int W = 8;

  logic         Clk;
  logic         Reset;
  logic         Execute;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         Div_By_Zero;

  int errors = 0;
  int checks = 0;

  divide_control #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Execute     (Execute),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Busy        (Busy),
    .Done        (Done),
    .Div_By_Zero (Div_By_Zero)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    Reset    = 1'b0;
    Execute  = 1'b0;
    Dividend = '0;
    Divisor  = '0;
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Presses Execute with the given operands and waits (bounded) for Done.
  // Counts the sampled cycles in which Busy was high. Execute stays held.
  task automatic do_division(input logic [W-1:0] dd, input logic [W-1:0] dv,
                             output int busy_cycles, output bit timed_out);
    @(negedge Clk);
    Dividend = dd;
    Divisor  = dv;
    Execute  = 1'b1;
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        timed_out = 1'b0;
        break;
      end
      if (Busy) busy_cycles++;
    end
  endtask

  task automatic release_execute();
    @(negedge Clk);
    Execute = 1'b0;
    @(negedge Clk);
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    Reset   = 1'b0;
    Execute = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (Quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d want 0", Quotient); end
    checks++; if (Remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder: got %0d want 0", Remainder); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (Div_By_Zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", Div_By_Zero); end
    // Execute low keeps it idle.
    repeat (3) @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_basic();
    int bc;
    bit to;
    do_division(8'd100, 8'd7, bc, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: Done never rose"); end
    checks++; if (bc != 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
    checks++; if (Quotient !== 8'd14) begin errors++; $display("FAIL basic_quotient: got %0d want 14", Quotient); end
    checks++; if (Remainder !== 8'd2) begin errors++; $display("FAIL basic_remainder: got %0d want 2", Remainder); end
    checks++; if (Div_By_Zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", Div_By_Zero); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_halt: got %b want 0", Busy); end
    release_execute();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL basic_release_done: got %b want 0", Done); end
    checks++; if (Quotient !== 8'd14) begin errors++; $display("FAIL basic_release_quotient: got %0d want 14", Quotient); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] dd_t [5] = '{8'd255, 8'd255, 8'd5, 8'd128, 8'd0};
    logic [W-1:0] dv_t [5] = '{8'd1,   8'd255, 8'd9, 8'd3,   8'd13};
    logic [W-1:0] q_t  [5] = '{8'd255, 8'd1,   8'd0, 8'd42,  8'd0};
    logic [W-1:0] r_t  [5] = '{8'd0,   8'd0,   8'd5, 8'd2,   8'd0};
    int bc;
    bit to;
    for (int i = 0; i < 5; i++) begin
      do_division(dd_t[i], dv_t[i], bc, to);
      checks++; if (to) begin errors++; $display("FAIL bound_timeout[%0d]: Done never rose", i); end
      checks++; if (bc != 17) begin errors++; $display("FAIL bound_busy_cycles[%0d]: got %0d want 17", i, bc); end
      checks++; if (Quotient !== q_t[i]) begin errors++; $display("FAIL bound_quotient[%0d] %0d/%0d: got %0d want %0d", i, dd_t[i], dv_t[i], Quotient, q_t[i]); end
      checks++; if (Remainder !== r_t[i]) begin errors++; $display("FAIL bound_remainder[%0d] %0d/%0d: got %0d want %0d", i, dd_t[i], dv_t[i], Remainder, r_t[i]); end
      checks++; if (Div_By_Zero !== 1'b0) begin errors++; $display("FAIL bound_dbz[%0d]: got %b want 0", i, Div_By_Zero); end
      release_execute();
    end
  endtask

  task automatic test_div_by_zero();
    int bc;
    bit to;
    do_division(8'd200, 8'd0, bc, to);
    checks++; if (to) begin errors++; $display("FAIL dbz_timeout: Done never rose"); end
    checks++; if (bc != 1) begin errors++; $display("FAIL dbz_busy_cycles: got %0d want 1", bc); end
    checks++; if (Quotient !== 8'hFF) begin errors++; $display("FAIL dbz_quotient: got %0h want ff", Quotient); end
    checks++; if (Remainder !== 8'd200) begin errors++; $display("FAIL dbz_remainder: got %0d want 200", Remainder); end
    checks++; if (Div_By_Zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", Div_By_Zero); end
    release_execute();
    checks++; if (Div_By_Zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_sticky: got %b want 1", Div_By_Zero); end
    do_division(8'd9, 8'd4, bc, to);
    checks++; if (to) begin errors++; $display("FAIL dbz_next_timeout: Done never rose"); end
    checks++; if (Quotient !== 8'd2) begin errors++; $display("FAIL dbz_next_quotient: got %0d want 2", Quotient); end
    checks++; if (Remainder !== 8'd1) begin errors++; $display("FAIL dbz_next_remainder: got %0d want 1", Remainder); end
    checks++; if (Div_By_Zero !== 1'b0) begin errors++; $display("FAIL dbz_next_flag: got %b want 0", Div_By_Zero); end
    release_execute();
  endtask

  task automatic test_hold_and_operand_change();
    int busy_seen;
    int not_done;
    bit to;
    // 77/5 = 15 r 2; operands change to 200/3 after Load.
    @(negedge Clk);
    Dividend = 8'd77;
    Divisor  = 8'd5;
    Execute  = 1'b1;
    repeat (3) @(negedge Clk);
    Dividend = 8'd200;
    Divisor  = 8'd3;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL hold_timeout: Done never rose"); end
    checks++; if (Quotient !== 8'd15) begin errors++; $display("FAIL hold_quotient: got %0d want 15", Quotient); end
    checks++; if (Remainder !== 8'd2) begin errors++; $display("FAIL hold_remainder: got %0d want 2", Remainder); end
    busy_seen = 0;
    not_done  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Busy) busy_seen++;
      if (!Done) not_done++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL hold_second_run: busy seen %0d cycles want 0", busy_seen); end
    checks++; if (not_done != 0) begin errors++; $display("FAIL hold_left_halt: not done %0d cycles want 0", not_done); end
    release_execute();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL hold_release_done: got %b want 0", Done); end
    checks++; if (Quotient !== 8'd15) begin errors++; $display("FAIL hold_release_quotient: got %0d want 15", Quotient); end
    checks++; if (Remainder !== 8'd2) begin errors++; $display("FAIL hold_release_remainder: got %0d want 2", Remainder); end
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL hold_idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_async_reset();
    int bc;
    bit to;
    @(negedge Clk);
    Dividend = 8'd100;
    Divisor  = 8'd7;
    Execute  = 1'b1;
    bc = 0;
    for (int i = 0; i < 20 && bc < 5; i++) begin
      @(negedge Clk);
      if (Busy) bc++;
    end
    checks++; if (bc != 5) begin errors++; $display("FAIL arst_reach_busy: got %0d busy cycles want 5", bc); end
    // Assert reset between edges and look before the next posedge.
    #2 Reset = 1'b0;
    #1;
    checks++; if (Quotient !== 8'd0) begin errors++; $display("FAIL arst_quotient: got %0d want 0", Quotient); end
    checks++; if (Remainder !== 8'd0) begin errors++; $display("FAIL arst_remainder: got %0d want 0", Remainder); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", Done); end
    checks++; if (Div_By_Zero !== 1'b0) begin errors++; $display("FAIL arst_dbz: got %b want 0", Div_By_Zero); end
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    bc = 0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        to = 1'b0;
        break;
      end
      if (Busy) bc++;
    end
    checks++; if (to) begin errors++; $display("FAIL arst_rerun_timeout: Done never rose"); end
    checks++; if (bc != 17) begin errors++; $display("FAIL arst_rerun_busy_cycles: got %0d want 17", bc); end
    checks++; if (Quotient !== 8'd14) begin errors++; $display("FAIL arst_rerun_quotient: got %0d want 14", Quotient); end
    checks++; if (Remainder !== 8'd2) begin errors++; $display("FAIL arst_rerun_remainder: got %0d want 2", Remainder); end
    release_execute();
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_hold_and_operand_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
